lutk_frame_config_dffesr_srl: RTL
=================================

# lutk_frame_config_dffesr_srl

Parametrised K-input LUT basic element with optional registered output, iCE40-style carry logic, and a configurable shift-register (SRL) mode in which the LUT truth table becomes a user-clocked, addressable shift register. It replaces the fixed 4-input LUT BEL in logic tiles. It is configured through frame config bits, and its ports connect to the tile switch matrix. In SRL mode it provides variable-length delay lines, and SRLs in adjacent BELs cascade through SI/SO.

## Interface
Parameters:
- K, default 4: number of LUT inputs. Legal range is 3..6.
- NoConfigBits, default 20: must equal 2^K + 4.

Ports:
- UserCLK  in  1: user clock. EXTERNAL and SHARED_PORT. All state changes on its rising edge.
- SR  in  1: reset, synchronous, active-high.
- EN  in  1: clock enable for the output FF and the SRL array.
- I  in  K: LUT inputs. I[0] is the LSB of the LUT index.
- Ci  in  1: carry-in.
- Co  out  1: carry-out.
- SI  in  1: shift-in, used in SRL mode only.
- SO  out  1: shift-out (array MSB), for cascading to the next BEL's SI.
- O  out  1: BEL output, either combinational or registered.
- ConfigBits  in  NoConfigBits: GLOBAL. Static frame configuration.

Config bit map (N = 2^K):
- [N-1:0]: INIT, the truth table.
- [N]: FF. 1 selects the registered output.
- [N+1]: IOmux. 1 replaces I[0] with Ci in the index.
- [N+2]: SET_NORESET, the FF value loaded by SR.
- [N+3]: SRL_MODE.

## Operation
- Index: idx = {I[K-1:1], IOmux ? Ci : I[0]}.
- LUT mode (SRL_MODE=0):
  - lut_out = INIT[idx], purely combinational from ConfigBits.
  - The mem array is frozen and does not shift.
  - SO = 0.
- SRL mode (SRL_MODE=1):
  - mem[N-1:0] is a user register array.
  - SR=1: mem <= INIT.
  - Otherwise, EN=1: mem <= {mem[N-2:0], SI}.
  - Otherwise: hold.
  - lut_out = mem[idx] (variable tap).
  - SO = mem[N-1].
- Output FF:
  - SR=1: flop <= SET_NORESET. SR dominates regardless of EN, which differs from the 4-input BEL.
  - Otherwise, EN=1: flop <= lut_out.
  - Otherwise: hold.
- O = FF ? flop : lut_out.
- Co = (Ci & I[1]) | (Ci & I[2]) | (I[1] & I[2]), independent of mode.
- In SRL mode the FF samples the pre-shift lut_out, which is the tap value in the cycle before the edge.
- ConfigBits are static during operation. After any change to SRL_MODE or INIT, an SR pulse is required before mem contents are valid.
- Before the first SR, flop and mem are X in simulation. No power-on value is guaranteed.

## Timing
- lut_out, O (with FF=0) and Co are combinational from I, Ci and mem: zero-cycle latency.
- With FF=1, O reflects lut_out one edge after it is sampled with EN=1.
- After one SR edge:
  - flop = SET_NORESET, so O = SET_NORESET if FF=1.
  - In SRL mode, mem = INIT and SO = INIT[N-1].
- SRL delay: a SI value sampled at edge t is visible at tap a after edge t+a, i.e. a+1 enabled edges of delay counting edge t. It reaches SO after N enabled edges.
- EN=0 edges do not advance mem or flop. The delay counts enabled edges only.
- SR and EN both high: the reset takes effect and no shift occurs on that edge.
- SR mid-shift: mem is fully reloaded from INIT on that edge. Data in flight is discarded.
- Cascade: BEL0.SO to BEL1.SI gives a 2N-deep chain with no extra latency per stage.

## Test plan
- K=4, LUT mode, INIT=16'h8000, FF=0: sweep I over 0..15. O=1 only at I=4'hF; SO stays 0.
- FF=1, SET_NORESET=1:
  - SR=1 with EN=0 for one edge: O=1.
  - Then SR=0, EN=1, INIT=0: O=0 after one edge.
  - EN=0 with INIT changed to all-ones: O holds 0.
- IOmux=1, INIT=16'hAAAA: O follows Ci and I[0] is ignored. Ci=1, I[1]=1, I[2]=0 gives Co=1; Ci=0, I[1]=1, I[2]=0 gives Co=0.
- SRL mode, K=4, INIT=0, SR, EN=1, then a single SI=1 pulse followed by zeros, with I=3 and FF=0:
  - O=1 only after edge 4.
  - SO=1 only after edge 16.
  - Inserting 2 EN=0 cycles delays both by 2.
- SRL mode, INIT=16'h1234: SR pulse asserted mid-shift. The next cycle's taps read 0x1234 bit-for-bit and SO=0. SR and EN both high causes no shift.
- K=6 instance (NoConfigBits=68) and a cascaded pair with K=4: a single SI pulse emerges at SO after 64 and 32 enabled edges respectively. Tap I=63 matches SO.

Source files
------------

// File: rtl/lutk_frame_config_dffesr_srl_if.sv
// Switch-matrix and frame-config bundle for one K-input LUT/SRL BEL.
// The bench drives the master side; the BEL sits on the slave side.
interface lutk_frame_config_dffesr_srl_if #(
  parameter int K            = 4,
  parameter int NoConfigBits = (1 << K) + 4
);
  logic                    i_en;
  logic [K-1:0]            i_lutIn;
  logic                    i_ci;
  logic                    i_si;
  logic [NoConfigBits-1:0] i_configBits;
  logic                    o_co;
  logic                    o_so;
  logic                    o_out;

  modport master (
    output i_en, i_lutIn, i_ci, i_si, i_configBits,
    input  o_co, o_so, o_out
  );

  modport slave (
    input  i_en, i_lutIn, i_ci, i_si, i_configBits,
    output o_co, o_so, o_out
  );
endinterface

// File: rtl/lutk_frame_config_dffesr_srl.sv
// K-input LUT BEL with optional output flop, carry majority and an SRL mode
// in which the truth table becomes an addressable, cascadable shift register.
module lutk_frame_config_dffesr_srl #(
  parameter int K            = 4,
  parameter int NoConfigBits = 20
) (
  input logic                          i_userClk,
  input logic                          i_sr,
  lutk_frame_config_dffesr_srl_if.slave bus
);
  localparam int N = 1 << K;

  logic [N-1:0] w_init;
  logic         w_ffSel;
  logic         w_ioMux;
  logic         w_setNoReset;
  logic         w_srlMode;
  logic [K-1:0] w_idx;
  logic         w_lutOut;

  logic [N-1:0] r_mem;
  logic         r_flop;

  assign w_init       = bus.i_configBits[N-1:0];
  assign w_ffSel      = bus.i_configBits[N];
  assign w_ioMux      = bus.i_configBits[N+1];
  assign w_setNoReset = bus.i_configBits[N+2];
  assign w_srlMode    = bus.i_configBits[NoConfigBits-1];

  // With IOmux set the carry-in takes the place of I[0] as the index LSB.
  assign w_idx = {bus.i_lutIn[K-1:1], w_ioMux ? bus.i_ci : bus.i_lutIn[0]};

  // The array only moves in SRL mode; in LUT mode it stays frozen.
  always_ff @(posedge i_userClk) begin
    if (w_srlMode) begin
      if (i_sr) begin
        r_mem <= w_init;
      end else if (bus.i_en) begin
        r_mem <= {r_mem[N-2:0], bus.i_si};
      end
    end
  end

  assign w_lutOut = w_srlMode ? r_mem[w_idx] : w_init[w_idx];

  // SR wins over EN, so a reset edge never captures the LUT value.
  always_ff @(posedge i_userClk) begin
    if (i_sr) begin
      r_flop <= w_setNoReset;
    end else if (bus.i_en) begin
      r_flop <= w_lutOut;
    end
  end

  assign bus.o_out = w_ffSel ? r_flop : w_lutOut;
  assign bus.o_so  = w_srlMode ? r_mem[N-1] : 1'b0;
  assign bus.o_co  = (bus.i_ci & bus.i_lutIn[1]) | (bus.i_ci & bus.i_lutIn[2]) |
                     (bus.i_lutIn[1] & bus.i_lutIn[2]);
endmodule
